// File: rtl/mf_disp_sys_wr_decode_pkg.sv
// Shared address-map constants, swap FSM states and the region decoder
// for the display system write port.
package mf_disp_sys_wr_decode_pkg;

  localparam int FB_WORDS_DEF    = 16000;
  localparam int PAL_ENTRIES_DEF = 64;

  localparam logic [15:0] FB_LIMIT  = 16'hFA00;
  localparam logic [15:0] PAL_BASE  = 16'hFA00;
  localparam logic [15:0] CTRL_ADDR = 16'hFE00;
  localparam logic [15:0] SWAP_ADDR = 16'hFE04;

  typedef enum logic {
    IDLE,
    PEND
  } swap_state_t;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_FB,
    RGN_PAL,
    RGN_CTRL,
    RGN_SWAP
  } region_t;

  // RGN_NONE covers every address that must be dropped and counted.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input int fb_words,
                                            input int pal_entries);
    logic [15:0] a;
    region_t     rgn;
    a   = addr[15:0];
    rgn = RGN_NONE;
    if (addr[31:16] == 16'h0 && addr[1:0] == 2'b00) begin
      if (a < FB_LIMIT && 32'(a[15:2]) < fb_words)
        rgn = RGN_FB;
      else if (a[15:8] == PAL_BASE[15:8] && 32'(a[7:2]) < pal_entries)
        rgn = RGN_PAL;
      else if (a == CTRL_ADDR)
        rgn = RGN_CTRL;
      else if (a == SWAP_ADDR)
        rgn = RGN_SWAP;
    end
    return rgn;
  endfunction

endpackage

// File: rtl/mf_disp_sys_wr_decode_swap.sv
// Front/back buffer ownership: IDLE/PEND swap machine that flips front_buf
// immediately when the display is disabled, otherwise on the frame boundary.
module mf_disp_swap_ctrl
  import mf_disp_sys_wr_decode_pkg::*;
(
  input  logic sys_clk,
  input  logic reset,
  input  logic swap_req,
  input  logic disable_req,
  input  logic ctrl_enable,
  input  logic frame_start,
  output logic front_buf,
  output logic swap_pending
);

  swap_state_t state;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= IDLE;
      front_buf    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // frame_start alongside a request is ignored here: the swap waits for the next one
          if (swap_req) begin
            if (ctrl_enable) begin
              state        <= PEND;
              swap_pending <= 1'b1;
            end else begin
              front_buf <= ~front_buf;
            end
          end
        end
        PEND: begin
          if (frame_start || disable_req) begin
            front_buf    <= ~front_buf;
            state        <= IDLE;
            swap_pending <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          swap_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mf_disp_sys_wr_decode.sv
// System write port decoder: routes writes to frame buffer, palette and
// control registers, counts dropped writes and hosts the buffer swap machine.
module mf_disp_sys_wr_decode
  import mf_disp_sys_wr_decode_pkg::*;
#(
  parameter int FB_WORDS    = FB_WORDS_DEF,
  parameter int PAL_ENTRIES = PAL_ENTRIES_DEF
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        sys_wr_vld,
  input  logic [31:0] sys_wr_addr,
  input  logic [31:0] sys_wr_data,
  input  logic        frame_start,
  output logic        fb_wr_en,
  output logic        fb_wr_buf,
  output logic [13:0] fb_wr_addr,
  output logic [31:0] fb_wr_data,
  output logic        pal_wr_en,
  output logic [5:0]  pal_wr_idx,
  output logic [17:0] pal_wr_data,
  output logic        ctrl_enable,
  output logic        ctrl_test_mode,
  output logic        front_buf,
  output logic        swap_pending,
  output logic [7:0]  err_count
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  region_t rgn_p0;
  logic    fb_p0, pal_p0, ctrl_p0, swap_req_p0, dis_req_p0, err_p0;

  // Stage p0: combinational decode of the incoming write
  always_comb begin
    rgn_p0      = decode_region(sys_wr_addr, FB_WORDS, PAL_ENTRIES);
    fb_p0       = sys_wr_vld && (rgn_p0 == RGN_FB);
    pal_p0      = sys_wr_vld && (rgn_p0 == RGN_PAL);
    ctrl_p0     = sys_wr_vld && (rgn_p0 == RGN_CTRL);
    swap_req_p0 = sys_wr_vld && (rgn_p0 == RGN_SWAP) && sys_wr_data[0];
    dis_req_p0  = ctrl_p0 && !sys_wr_data[0];
    err_p0      = sys_wr_vld && (rgn_p0 == RGN_NONE);
  end

  // Stage p1: registered strobes, payloads, control and error count
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      fb_wr_en       <= 1'b0;
      fb_wr_buf      <= 1'b0;
      fb_wr_addr     <= '0;
      fb_wr_data     <= '0;
      pal_wr_en      <= 1'b0;
      pal_wr_idx     <= '0;
      pal_wr_data    <= '0;
      ctrl_enable    <= 1'b0;
      ctrl_test_mode <= 1'b0;
      err_count      <= '0;
    end else begin
      fb_wr_en  <= fb_p0;
      pal_wr_en <= pal_p0;
      if (fb_p0) begin
        fb_wr_buf  <= ~front_buf;
        fb_wr_addr <= sys_wr_addr[15:2];
        fb_wr_data <= sys_wr_data;
      end
      if (pal_p0) begin
        pal_wr_idx  <= sys_wr_addr[7:2];
        pal_wr_data <= sys_wr_data[17:0];
      end
      if (ctrl_p0) begin
        ctrl_enable    <= sys_wr_data[0];
        ctrl_test_mode <= sys_wr_data[2];
      end
      if (err_p0)
        err_count <= sat_inc(err_count);
    end
  end

  mf_disp_swap_ctrl u_swap (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .swap_req     (swap_req_p0),
    .disable_req  (dis_req_p0),
    .ctrl_enable  (ctrl_enable),
    .frame_start  (frame_start),
    .front_buf    (front_buf),
    .swap_pending (swap_pending)
  );

endmodule

// File: tb/tb_mf_disp_sys_wr_decode.sv
// Directed bench for mf_disp_sys_wr_decode with a strobe scoreboard.
module tb_mf_disp_sys_wr_decode;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        sys_wr_vld;
  logic [31:0] sys_wr_addr;
  logic [31:0] sys_wr_data;
  logic        frame_start;
  logic        fb_wr_en;
  logic        fb_wr_buf;
  logic [13:0] fb_wr_addr;
  logic [31:0] fb_wr_data;
  logic        pal_wr_en;
  logic [5:0]  pal_wr_idx;
  logic [17:0] pal_wr_data;
  logic        ctrl_enable;
  logic        ctrl_test_mode;
  logic        front_buf;
  logic        swap_pending;
  logic [7:0]  err_count;

  mf_disp_sys_wr_decode dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .sys_wr_vld     (sys_wr_vld),
    .sys_wr_addr    (sys_wr_addr),
    .sys_wr_data    (sys_wr_data),
    .frame_start    (frame_start),
    .fb_wr_en       (fb_wr_en),
    .fb_wr_buf      (fb_wr_buf),
    .fb_wr_addr     (fb_wr_addr),
    .fb_wr_data     (fb_wr_data),
    .pal_wr_en      (pal_wr_en),
    .pal_wr_idx     (pal_wr_idx),
    .pal_wr_data    (pal_wr_data),
    .ctrl_enable    (ctrl_enable),
    .ctrl_test_mode (ctrl_test_mode),
    .front_buf      (front_buf),
    .swap_pending   (swap_pending),
    .err_count      (err_count)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    bit          is_pal;
    bit          bsel;
    logic [13:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_fb(input bit bsel, input logic [13:0] a, input logic [31:0] d);
    q.push_back('{1'b0, bsel, a, d, cyc + 1});
  endtask

  task automatic push_pal(input logic [5:0] idx, input logic [17:0] d);
    q.push_back('{1'b1, 1'b0, 14'(idx), 32'(d), cyc + 1});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    sys_wr_vld  = 1'b1;
    sys_wr_addr = a;
    sys_wr_data = d;
    tick(1);
    sys_wr_vld  = 1'b0;
    sys_wr_addr = '0;
    sys_wr_data = '0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the scoreboard, one cycle after issue
  always @(negedge sys_clk) begin
    exp_t e;
    if (fb_wr_en && pal_wr_en) begin
      vectors++;
      miscompares++;
      $display("FAIL both_strobes: fb_wr_en=1 pal_wr_en=1, required at most one");
    end else if (fb_wr_en || pal_wr_en) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: fb=%0b pal=%0b addr=%0h idx=%0h at cycle %0d, none expected",
                 fb_wr_en, pal_wr_en, fb_wr_addr, pal_wr_idx, cyc);
      end else begin
        e = q.pop_front();
        if (e.is_pal) begin
          if (!pal_wr_en || pal_wr_idx !== e.addr[5:0] || pal_wr_data !== e.data[17:0] || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL pal_strobe: got en=%0b idx=%0h data=%0h cyc=%0d, expected idx=%0h data=%0h cyc=%0d",
                     pal_wr_en, pal_wr_idx, pal_wr_data, cyc, e.addr[5:0], e.data[17:0], e.cyc);
          end
        end else begin
          if (!fb_wr_en || fb_wr_buf !== e.bsel || fb_wr_addr !== e.addr || fb_wr_data !== e.data || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL fb_strobe: got en=%0b buf=%0b addr=%0h data=%0h cyc=%0d, expected buf=%0b addr=%0h data=%0h cyc=%0d",
                     fb_wr_en, fb_wr_buf, fb_wr_addr, fb_wr_data, cyc, e.bsel, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    sys_wr_vld  = 1'b0;
    sys_wr_addr = '0;
    sys_wr_data = '0;
    frame_start = 1'b0;
    tick(3);
    chk("rst_fb_wr_en", 32'(fb_wr_en), 0);
    chk("rst_pal_wr_en", 32'(pal_wr_en), 0);
    chk("rst_ctrl", {ctrl_enable, ctrl_test_mode, front_buf, swap_pending}, 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_fb_addr_data", {18'(fb_wr_addr), 14'(fb_wr_data)}, 0);
    chk("rst_pal_idx_data", {8'(pal_wr_idx), 24'(pal_wr_data)}, 0);
    reset = 1'b0;
    tick(1);

    // Palette writes
    push_pal(6'd1, 18'h3F000);
    wr(32'h0000_FA04, 32'h0003_F000);
    push_pal(6'd3, 18'h3FFFF);
    wr(32'h0000_FA0C, 32'h0003_FFFF);
    push_pal(6'd63, 18'h00ABC);
    wr(32'h0000_FAFC, 32'hFFFC_0ABC);

    // Back-to-back frame buffer writes into the back buffer (front is 0)
    push_fb(1'b1, 14'h0000, 32'h1122_3344);
    wr(32'h0000_0000, 32'h1122_3344);
    push_fb(1'b1, 14'h004D, 32'hA5A5_0F0F);
    wr(32'h0000_0134, 32'hA5A5_0F0F);
    push_fb(1'b1, 14'h3E7F, 32'hDEAD_BEEF);
    wr(32'h0000_F9FC, 32'hDEAD_BEEF);
    tick(1);
    chk("err_after_good", 32'(err_count), 0);

    // Dropped writes: misaligned, high address bits, holes in the map
    wr(32'h0000_FA02, 32'h1);
    wr(32'h0001_0000, 32'h1);
    wr(32'h0000_FB00, 32'h1);
    tick(1);
    chk("err_three", 32'(err_count), 3);
    wr(32'h0000_FE08, 32'h1);
    chk("err_four", 32'(err_count), 4);
    chk("ctrl_untouched", {ctrl_enable, front_buf, swap_pending}, 0);

    // Swap while enabled
    wr(32'h0000_FE00, 32'h1);
    chk("ctrl_enable_set", {ctrl_enable, ctrl_test_mode}, 2'b10);
    wr(32'h0000_FE04, 32'h1);
    chk("pend_after_req", {front_buf, swap_pending}, 2'b01);
    tick(3);
    chk("pend_holds", {front_buf, swap_pending}, 2'b01);
    wr(32'h0000_FE04, 32'h1);
    chk("second_req", {front_buf, swap_pending}, 2'b01);
    chk("second_req_no_err", 32'(err_count), 4);
    push_fb(1'b1, 14'h0004, 32'h0102_0304);
    wr(32'h0000_0010, 32'h0102_0304);
    pulse_fs();
    chk("swap_applied", {front_buf, swap_pending}, 2'b10);
    tick(2);
    chk("single_toggle", {front_buf, swap_pending}, 2'b10);
    push_fb(1'b0, 14'h0005, 32'hCAFE_F00D);
    wr(32'h0000_0014, 32'hCAFE_F00D);
    wr(32'h0000_FE00, 32'h5);
    chk("test_mode_set", {ctrl_enable, ctrl_test_mode}, 2'b11);

    // Request and frame_start together in IDLE: swap waits for the next frame_start
    sys_wr_vld  = 1'b1;
    sys_wr_addr = 32'h0000_FE04;
    sys_wr_data = 32'h1;
    frame_start = 1'b1;
    tick(1);
    sys_wr_vld  = 1'b0;
    frame_start = 1'b0;
    chk("req_with_fs", {front_buf, swap_pending}, 2'b11);
    pulse_fs();
    chk("req_with_fs_applied", {front_buf, swap_pending}, 2'b00);

    // Disabling during PEND applies the swap at once
    wr(32'h0000_FE04, 32'h1);
    chk("pend_again", {front_buf, swap_pending}, 2'b01);
    wr(32'h0000_FE00, 32'h0);
    chk("disable_swap", {ctrl_enable, front_buf, swap_pending}, 3'b010);

    // Swap while disabled toggles on the next cycle; bit0=0 is a no-op
    wr(32'h0000_FE04, 32'h1);
    chk("disabled_swap", {front_buf, swap_pending}, 2'b00);
    wr(32'h0000_FE04, 32'h0);
    chk("swap_bit0_zero", {front_buf, swap_pending}, 2'b00);
    chk("swap_bit0_zero_err", 32'(err_count), 4);

    // Saturation
    for (int i = 0; i < 300; i++) wr(32'h0001_0000, 32'h0);
    chk("err_saturated", 32'(err_count), 255);

    // Reset mid-swap discards the request
    wr(32'h0000_FE00, 32'h1);
    wr(32'h0000_FE04, 32'h1);
    chk("pend_before_reset", {front_buf, swap_pending}, 2'b01);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("reset_ctrl", {ctrl_enable, ctrl_test_mode, front_buf, swap_pending}, 0);
    chk("reset_err", 32'(err_count), 0);
    chk("reset_fb_addr_data", {18'(fb_wr_addr), 14'(fb_wr_data)}, 0);
    chk("reset_pal_idx_data", {8'(pal_wr_idx), 24'(pal_wr_data)}, 0);
    pulse_fs();
    chk("fs_after_reset", {front_buf, swap_pending}, 0);

    tick(2);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
